// File: rtl/fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// fwd_hazard_unit
//
// Forwarding and load-use hazard unit for the EX stage of the pipelined MIPS
// core. A small shift-register scoreboard remembers the destination of each of
// the DEPTH instructions that have already left EX. Entry 0 is the instruction
// now in MA and entry DEPTH-1 is the one in WB. From that table the unit
// produces three things:
//   - a forwarding select for every EX source operand
//   - a stall request when a load result cannot be forwarded yet
//   - a saturating count of stalled cycles, used for performance monitoring
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   ex_valid   : EX holds a real instruction
//   ex_src     : EX source register numbers; source s is at [s*REG_AW +: REG_AW]
//   ex_src_use : source s is actually read by the EX instruction
//   ex_dst     : EX destination register
//   ex_wr_en   : EX instruction writes ex_dst
//   ex_is_load : EX instruction is a load
//   flush      : kill the EX instruction this cycle
//   cnt_clr    : synchronous clear of stall_cnt
//   fwd_sel    : per source, 0 = regfile, k+1 = forward from entry k
//   stall      : hold IF/ID/EX this cycle
//   stall_cnt  : saturating count of stalled cycles
// ---------------------------------------------------------------------------
module fwd_hazard_unit #(
  parameter  int REG_AW   = 5,
  parameter  int NUM_SRC  = 2,
  parameter  int DEPTH    = 2,
  parameter  int LOAD_LAT = 1,
  parameter  int CNT_W    = 16,
  localparam int SEL_W    = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ex_valid,
  input  logic [NUM_SRC*REG_AW-1:0] ex_src,
  input  logic [NUM_SRC-1:0]        ex_src_use,
  input  logic [REG_AW-1:0]         ex_dst,
  input  logic                      ex_wr_en,
  input  logic                      ex_is_load,
  input  logic                      flush,
  input  logic                      cnt_clr,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic                      stall,
  output logic [CNT_W-1:0]          stall_cnt
);

  // Scoreboard storage: one bit vector per field, indexed by entry.
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  wr_en_q, wr_en_d;
  logic [DEPTH-1:0]  is_load_q, is_load_d;
  logic [REG_AW-1:0] dst_q [DEPTH];
  logic [REG_AW-1:0] dst_d [DEPTH];
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [NUM_SRC-1:0] hazard;

  // Forwarding select and load hazard for each source.
  // The loop runs from the oldest entry to the youngest, so the youngest
  // match overwrites any older one. A load that is still too young to
  // forward forces the select back to the regfile and raises a hazard.
  always_comb begin
    logic [SEL_W-1:0] sel_v;
    logic             hit_load;
    logic             hit_early;
    logic [REG_AW-1:0] src_v;
    fwd_sel = '0;
    hazard  = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      sel_v     = '0;
      hit_load  = 1'b0;
      hit_early = 1'b0;
      src_v     = ex_src[s*REG_AW +: REG_AW];
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (ex_src_use[s] && valid_q[k] && wr_en_q[k] &&
            (dst_q[k] == src_v) && (src_v != '0)) begin
          sel_v     = SEL_W'(k + 1);
          hit_load  = is_load_q[k];
          hit_early = (k < LOAD_LAT);
        end
      end
      hazard[s] = hit_load & hit_early;
      fwd_sel[s*SEL_W +: SEL_W] = hazard[s] ? '0 : sel_v;
    end
  end

  // Flush has priority over a hazard, so a killed instruction never stalls.
  assign stall = ex_valid & ~flush & (|hazard);

  // Next scoreboard contents. The table shifts on every edge. Entry 0
  // receives the EX instruction only when it really advances; otherwise it
  // receives a bubble.
  always_comb begin
    valid_d     = '0;
    wr_en_d     = '0;
    is_load_d   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      dst_d[k] = '0;
    end
    valid_d[0]   = ex_valid & ~stall & ~flush;
    wr_en_d[0]   = ex_wr_en;
    is_load_d[0] = ex_is_load;
    dst_d[0]     = ex_dst;
    for (int k = 1; k < DEPTH; k++) begin
      valid_d[k]   = valid_q[k-1];
      wr_en_d[k]   = wr_en_q[k-1];
      is_load_d[k] = is_load_q[k-1];
      dst_d[k]     = dst_q[k-1];
    end
  end

  // Stall counter: clear wins over increment, and the count holds at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
    end else if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // State registers. Reset clears every entry and the counter at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= '0;
      wr_en_q     <= '0;
      is_load_q   <= '0;
      stall_cnt_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        dst_q[k] <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      wr_en_q     <= wr_en_d;
      is_load_q   <= is_load_d;
      stall_cnt_q <= stall_cnt_d;
      for (int k = 0; k < DEPTH; k++) begin
        dst_q[k] <= dst_d[k];
      end
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_fwd_hazard_unit
//
// Drives two instances of fwd_hazard_unit with the same inputs:
//   - instance A uses the default configuration (DEPTH=2, LOAD_LAT=1)
//   - instance B uses DEPTH=3, LOAD_LAT=2 and a 4-bit counter
//
// A reference model keeps, for each instance, a history of the instructions
// that left EX, with the youngest first. Forwarding is found by searching
// that history for the youngest writer of each source register.
// ---------------------------------------------------------------------------
module tb_fwd_hazard_unit;

  typedef struct packed {
    bit       valid;
    bit [4:0] dst;
    bit       wr;
    bit       ld;
  } entry_t;

  logic       clk;
  logic       rst_n;
  logic       ex_valid;
  logic [9:0] ex_src;
  logic [1:0] ex_src_use;
  logic [4:0] ex_dst;
  logic       ex_wr_en;
  logic       ex_is_load;
  logic       flush;
  logic       cnt_clr;

  logic [3:0]  a_fwd;
  logic        a_stall;
  logic [15:0] a_cnt;
  logic [3:0]  b_fwd;
  logic        b_stall;
  logic [3:0]  b_cnt;

  int total;
  int bad;

  entry_t hist_a[$];
  entry_t hist_b[$];
  int     cnt_a;
  int     cnt_b;

  fwd_hazard_unit dut_a (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_src(ex_src),
    .ex_src_use(ex_src_use), .ex_dst(ex_dst), .ex_wr_en(ex_wr_en),
    .ex_is_load(ex_is_load), .flush(flush), .cnt_clr(cnt_clr),
    .fwd_sel(a_fwd), .stall(a_stall), .stall_cnt(a_cnt)
  );

  fwd_hazard_unit #(.DEPTH(3), .LOAD_LAT(2), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_src(ex_src),
    .ex_src_use(ex_src_use), .ex_dst(ex_dst), .ex_wr_en(ex_wr_en),
    .ex_is_load(ex_is_load), .flush(flush), .cnt_clr(cnt_clr),
    .fwd_sel(b_fwd), .stall(b_stall), .stall_cnt(b_cnt)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Find the youngest in-flight writer of one source register.
  // A load that is younger than lat cycles cannot forward yet, so it
  // counts as a hazard and the select falls back to the regfile.
  function automatic void model_src(input entry_t h[$], input int lat,
                                    input bit [4:0] src, input bit use_s,
                                    output int sel, output bit haz);
    sel = 0;
    haz = 1'b0;
    if (use_s && src != 5'd0) begin
      for (int k = 0; k < h.size(); k++) begin
        if (h[k].valid && h[k].wr && h[k].dst == src) begin
          sel = k + 1;
          haz = h[k].ld && (k < lat);
          break;
        end
      end
    end
    if (haz) sel = 0;
  endfunction

  // Model outputs of one instance for the inputs currently applied.
  function automatic void model_out(input entry_t h[$], input int lat,
                                    output logic [3:0] fsel, output logic st);
    int s0, s1;
    bit h0, h1;
    model_src(h, lat, ex_src[4:0], ex_src_use[0], s0, h0);
    model_src(h, lat, ex_src[9:5], ex_src_use[1], s1, h1);
    fsel = {2'(s1), 2'(s0)};
    st   = ex_valid && !flush && (h0 || h1);
  endfunction

  // Put both model histories back in their reset state: every
  // tracked slot holds a bubble and both counters are zero.
  task automatic reset_model();
    hist_a.delete();
    hist_b.delete();
    repeat (2) hist_a.push_back('0);
    repeat (3) hist_b.push_back('0);
    cnt_a = 0;
    cnt_b = 0;
  endtask

  // One comparison. Each call adds one to total, and a mismatch also
  // adds one to bad and reports the observed and expected values.
  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setInputs(input bit v, input bit [4:0] s0, input bit [4:0] s1,
                           input bit [1:0] use_v, input bit [4:0] dst,
                           input bit wr, input bit ld, input bit fl,
                           input bit clr);
    ex_valid   = v;
    ex_src     = {s1, s0};
    ex_src_use = use_v;
    ex_dst     = dst;
    ex_wr_en   = wr;
    ex_is_load = ld;
    flush      = fl;
    cnt_clr    = clr;
  endtask

  // Compare every output of both instances against the model.
  task automatic checkOutput();
    logic [3:0] fa, fb;
    logic       sa, sb;
    model_out(hist_a, 1, fa, sa);
    model_out(hist_b, 2, fb, sb);
    chk("a_fwd_sel", 32'(a_fwd), 32'(fa));
    chk("a_stall", 32'(a_stall), 32'(sa));
    chk("a_stall_cnt", 32'(a_cnt), cnt_a);
    chk("b_fwd_sel", 32'(b_fwd), 32'(fb));
    chk("b_stall", 32'(b_stall), 32'(sb));
    chk("b_stall_cnt", 32'(b_cnt), cnt_b);
  endtask

  // Advance one clock edge and update the model the same way: the new
  // instruction (or a bubble) enters at the young end, the oldest entry
  // drops off, and each counter is cleared or counts a stalled cycle.
  task automatic tick();
    logic [3:0] fa, fb;
    logic       sa, sb;
    entry_t     ne;
    entry_t     na[$];
    entry_t     nb[$];
    int         ca, cb;
    model_out(hist_a, 1, fa, sa);
    model_out(hist_b, 2, fb, sb);
    na = hist_a;
    nb = hist_b;
    ne = '{valid: 1'b1, dst: ex_dst, wr: ex_wr_en, ld: ex_is_load};
    na.push_front((ex_valid && !sa && !flush) ? ne : entry_t'('0));
    nb.push_front((ex_valid && !sb && !flush) ? ne : entry_t'('0));
    void'(na.pop_back());
    void'(nb.pop_back());
    ca = cnt_clr ? 0 : (sa ? ((cnt_a == 65535) ? 65535 : cnt_a + 1) : cnt_a);
    cb = cnt_clr ? 0 : (sb ? ((cnt_b == 15) ? 15 : cnt_b + 1) : cnt_b);
    @(posedge clk);
    #1;
    if (rst_n) begin
      hist_a = na;
      hist_b = nb;
      cnt_a  = ca;
      cnt_b  = cb;
    end else begin
      reset_model();
    end
  endtask

  // Apply one instruction: drive the inputs, check the outputs,
  // then clock once.
  task automatic applyStimulus(input bit v, input bit [4:0] s0,
                               input bit [4:0] s1, input bit [1:0] use_v,
                               input bit [4:0] dst, input bit wr, input bit ld,
                               input bit fl, input bit clr);
    setInputs(v, s0, s1, use_v, dst, wr, ld, fl, clr);
    #1;
    checkOutput();
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    setInputs(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    reset_model();

    // Reset state
    #12;
    chk("rst_a_fwd", 32'(a_fwd), 0);
    chk("rst_a_stall", 32'(a_stall), 0);
    chk("rst_a_cnt", 32'(a_cnt), 0);
    chk("rst_b_cnt", 32'(b_cnt), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back dependency: add $3 ; sub $4,$3,$5
    applyStimulus(1, 0, 0, 2'b00, 3, 1, 0, 0, 0);
    setInputs(1, 3, 5, 2'b11, 4, 1, 0, 0, 0);
    #1;
    checkOutput();
    chk("b2b_fwd0", 32'(a_fwd[1:0]), 1);
    chk("b2b_stall", 32'(a_stall), 0);
    tick();

    // Distance 2: add $3 ; nop ; or $6,$3,$3
    applyStimulus(1, 0, 0, 2'b00, 3, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    setInputs(1, 3, 3, 2'b11, 6, 1, 0, 0, 0);
    #1;
    checkOutput();
    chk("dist2_fwd", 32'(a_fwd), 32'h0a);
    tick();

    // Youngest wins: $3 is written in both MA and WB
    applyStimulus(1, 0, 0, 2'b00, 3, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 2'b00, 3, 1, 0, 0, 0);
    setInputs(1, 3, 0, 2'b01, 8, 1, 0, 0, 0);
    #1;
    checkOutput();
    chk("young_fwd0", 32'(a_fwd[1:0]), 1);
    tick();

    // Load-use: lw $2 ; add $7,$2,$1 (counter cleared with the lw)
    applyStimulus(1, 0, 0, 2'b00, 2, 1, 1, 0, 1);
    setInputs(1, 2, 1, 2'b11, 7, 1, 0, 0, 0);
    #1;
    checkOutput();
    chk("lu_a_stall1", 32'(a_stall), 1);
    chk("lu_b_stall1", 32'(b_stall), 1);
    tick();
    #1;
    checkOutput();
    chk("lu_a_stall2", 32'(a_stall), 0);
    chk("lu_a_fwd0", 32'(a_fwd[1:0]), 2);
    chk("lu_a_cnt", 32'(a_cnt), 1);
    chk("lu_b_stall2", 32'(b_stall), 1);
    tick();
    #1;
    checkOutput();
    chk("lu_b_stall3", 32'(b_stall), 0);
    chk("lu_b_fwd0", 32'(b_fwd[1:0]), 3);
    chk("lu_b_cnt", 32'(b_cnt), 2);
    tick();

    // Register 0 never matches; an unused source never matches
    applyStimulus(1, 0, 0, 2'b00, 3, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 2'b00, 0, 1, 0, 0, 0);
    setInputs(1, 0, 3, 2'b01, 9, 1, 0, 0, 0);
    #1;
    checkOutput();
    chk("edge_fwd", 32'(a_fwd), 0);
    tick();

    // Flush beats a hazard and leaves a bubble in entry 0
    applyStimulus(1, 0, 0, 2'b00, 2, 1, 1, 0, 0);
    setInputs(1, 2, 1, 2'b11, 7, 1, 0, 1, 0);
    #1;
    checkOutput();
    chk("flush_a_stall", 32'(a_stall), 0);
    chk("flush_b_stall", 32'(b_stall), 0);
    tick();
    setInputs(1, 7, 2, 2'b11, 9, 1, 0, 0, 0);
    #1;
    checkOutput();
    chk("flush_bubble_fwd", 32'(a_fwd), 32'h08);
    tick();

    // Reset asserted in the middle of a stall
    applyStimulus(1, 0, 0, 2'b00, 2, 1, 1, 0, 0);
    setInputs(1, 2, 1, 2'b11, 7, 1, 0, 0, 0);
    #1;
    checkOutput();
    chk("mid_a_stall", 32'(a_stall), 1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_a_stall", 32'(a_stall), 0);
    chk("rstmid_a_cnt", 32'(a_cnt), 0);
    chk("rstmid_b_stall", 32'(b_stall), 0);
    chk("rstmid_b_cnt", 32'(b_cnt), 0);
    reset_model();
    tick();
    rst_n = 1'b1;
    #1;
    checkOutput();
    chk("post_rst_fwd", 32'(a_fwd), 0);
    tick();

    // Counter saturation on B: each lw $5 reads $5 written by the previous one
    applyStimulus(0, 0, 0, 2'b00, 0, 0, 0, 0, 1);
    for (int i = 0; i < 45; i++) begin
      applyStimulus(1, 5, 0, 2'b01, 5, 1, 1, 0, 0);
    end
    chk("sat_b_cnt", 32'(b_cnt), 15);

    // Clear wins over increment: wait a bounded time for a stall cycle on B
    setInputs(1, 5, 0, 2'b01, 5, 1, 1, 0, 0);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (b_stall) break;
      tick();
    end
    chk("clr_pre_b_stall", 32'(b_stall), 1);
    cnt_clr = 1'b1;
    #1;
    tick();
    chk("clr_b_cnt", 32'(b_cnt), 0);
    chk("clr_a_cnt", 32'(a_cnt), 0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 7) != 0,
                    5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)),
                    2'($urandom_range(0, 3)), 5'($urandom_range(0, 4)),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 31) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
